dmem_arbiter: RTL

Two-requester arbiter that shares the single-port 1024×16 pixel data memory between the processor core (port 0) and the pixel streamer (port 1). It accepts at most one access per cycle, issues it to the memory through registered control/address/data outputs, and routes the read data back to the requester with a fixed latency. Access is round-robin by default; an optional lock extends ownership across multi-cycle bursts.

---
 rtl/dmem_arb_pkg.sv | 25 ++
 rtl/dmem_arb_rr.sv | 26 ++
 rtl/dmem_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the pixel data-memory arbiter: widths, port ids, read tag.
// Latency: n/a (types only).
// Backpressure: n/a.
package dmem_arb_pkg;

   localparam int DMEM_ADDR_W = 10;
   localparam int DMEM_DATA_W = 16;

   // Requester identity; the value doubles as the index into req/gnt vectors.
   typedef enum logic {
      PORT_CORE = 1'b0,
      PORT_PIX  = 1'b1
   } port_t;

   // Tag travelling alongside an issued read until its data comes back.
   typedef struct packed {
      logic  valid;
      port_t port;
   } tag_t;

   function automatic logic [1:0] port_onehot(input port_t p);
      return (p == PORT_PIX) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/dmem_arb_rr.sv
// Two-way combinational round-robin picker: grants the sole requester, or on
// contention the port that was not granted last. Latency: 0 (pure logic).
// Backpressure: none; losers simply see gnt low and keep requesting.
//
// Ports:
//   req_i  [1:0]  request per port
//   last_i        last port whose request was accepted
//   gnt_o  [1:0]  one-hot or zero grant
module dmem_arb_rr
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req_i,
   input  port_t      last_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = 2'b00;
      if (req_i == 2'b11) begin
         gnt_o = (last_i == PORT_CORE) ? 2'b10 : 2'b01;
      end else begin
         gnt_o = req_i;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port pixel data memory between core (port 0) and pixel
// streamer (port 1). Latency: grant same cycle, memory controls registered one
// cycle later, read data returned two cycles after acceptance. Backpressure:
// a requester holds its request until it sees gnt_o; one access per cycle.
//
// Ports:
//   clk, rst                     clock, synchronous active-low reset
//   req_i/we_i [1:0]             per-port request and write select
//   addr0_i/addr1_i, wdata0_i/wdata1_i   per-port address and write data
//   lock_i [1:0]                 keep ownership after this grant (lock build only)
//   gnt_o [1:0]                  combinational grant
//   rvalid_o [1:0], rdata_o      read return, rdata shared and qualified by rvalid
//   mem_writeEn/mem_readEn/mem_address/mem_dataIn   registered memory controls
//   mem_dataOut                  memory read data
//
// Build option: define DMEM_ARB_LOCK_EN to add lock_i and burst ownership,
// capped at LOCK_MAX consecutive locked acceptances.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W   = DMEM_ADDR_W,
   parameter int DATA_W   = DMEM_DATA_W
`ifdef DMEM_ARB_LOCK_EN
   ,
   parameter int LOCK_MAX = 16
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req_i,
   input  logic [1:0]        we_i,
   input  logic [ADDR_W-1:0] addr0_i,
   input  logic [ADDR_W-1:0] addr1_i,
   input  logic [DATA_W-1:0] wdata0_i,
   input  logic [DATA_W-1:0] wdata1_i,
`ifdef DMEM_ARB_LOCK_EN
   input  logic [1:0]        lock_i,
`endif
   output logic [1:0]        gnt_o,
   output logic [1:0]        rvalid_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              mem_writeEn,
   output logic              mem_readEn,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_dataIn,
   input  logic [DATA_W-1:0] mem_dataOut
);

   // ------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------
   port_t      last_q, last_d;
   logic [1:0] rr_gnt;
   logic [1:0] gnt_int;
   logic       accept;
   logic       win_sel;     // 1 = pixel port won this cycle
   port_t      win_port;
   logic       win_we;

   dmem_arb_rr u_rr (
      .req_i  (req_i),
      .last_i (last_q),
      .gnt_o  (rr_gnt)
   );

`ifdef DMEM_ARB_LOCK_EN
   localparam int CNT_W = $clog2(LOCK_MAX + 1);

   logic             owner_vld_q, owner_vld_d;
   port_t            owner_q,     owner_d;
   logic [CNT_W-1:0] lock_cnt_q,  lock_cnt_d;

   // An owner blocks the other port even while the owner itself is idle.
   always_comb begin
      gnt_int = rr_gnt;
      if (owner_vld_q) begin
         gnt_int = req_i & port_onehot(owner_q);
      end
   end
`else
   always_comb begin
      gnt_int = rr_gnt;
   end
`endif

   always_comb begin
      gnt_o    = rst ? gnt_int : 2'b00;
      accept   = |gnt_o;
      win_sel  = gnt_o[1];
      win_port = win_sel ? PORT_PIX : PORT_CORE;
      win_we   = win_sel ? we_i[1] : we_i[0];
      last_d   = accept ? win_port : last_q;
   end

`ifdef DMEM_ARB_LOCK_EN
   // The counter only runs while owned, so it is zero whenever ownership
   // starts; reaching LOCK_MAX-1 before this acceptance means this is the
   // final locked grant and ownership is released right away.
   always_comb begin
      owner_vld_d = owner_vld_q;
      owner_d     = owner_q;
      lock_cnt_d  = lock_cnt_q;
      if (accept) begin
         if (lock_i[win_sel]) begin
            if (lock_cnt_q == CNT_W'(LOCK_MAX - 1)) begin
               owner_vld_d = 1'b0;
               lock_cnt_d  = '0;
            end else begin
               owner_vld_d = 1'b1;
               owner_d     = win_port;
               lock_cnt_d  = lock_cnt_q + CNT_W'(1);
            end
         end else begin
            owner_vld_d = 1'b0;
            lock_cnt_d  = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         owner_vld_q <= 1'b0;
         owner_q     <= PORT_CORE;
         lock_cnt_q  <= '0;
      end else begin
         owner_vld_q <= owner_vld_d;
         owner_q     <= owner_d;
         lock_cnt_q  <= lock_cnt_d;
      end
   end
`endif

   // ------------------------------------------------------------------
   // Issue registers
   // ------------------------------------------------------------------
   logic              wen_q,  wen_d;
   logic              ren_q,  ren_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdat_q, wdat_d;

   // Address/data hold when idle so the memory pins only toggle on real accesses.
   always_comb begin
      wen_d  = accept & win_we;
      ren_d  = accept & ~win_we;
      addr_d = addr_q;
      wdat_d = wdat_q;
      if (accept) begin
         addr_d = win_sel ? addr1_i  : addr0_i;
         wdat_d = win_sel ? wdata1_i : wdata0_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wen_q  <= 1'b0;
         ren_q  <= 1'b0;
         addr_q <= '0;
         wdat_q <= '0;
         last_q <= PORT_PIX;   // so the core wins the first contention
      end else begin
         wen_q  <= wen_d;
         ren_q  <= ren_d;
         addr_q <= addr_d;
         wdat_q <= wdat_d;
         last_q <= last_d;
      end
   end

   assign mem_writeEn = wen_q;
   assign mem_readEn  = ren_q;
   assign mem_address = addr_q;
   assign mem_dataIn  = wdat_q;

   // ------------------------------------------------------------------
   // Read-return tag pipeline: stage 1 lines up with the memory access,
   // stage 2 with the cycle the memory presents its data.
   // ------------------------------------------------------------------
   tag_t tag1_q, tag1_d;
   tag_t tag2_q, tag2_d;

   always_comb begin
      tag1_d       = '0;
      tag1_d.valid = accept & ~win_we;
      tag1_d.port  = win_port;
      tag2_d       = tag1_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         tag1_q <= '0;
         tag2_q <= '0;
      end else begin
         tag1_q <= tag1_d;
         tag2_q <= tag2_d;
      end
   end

   assign rvalid_o = tag2_q.valid ? port_onehot(tag2_q.port) : 2'b00;
   assign rdata_o  = mem_dataOut;

endmodule
